// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control sequencer and the bus encoder:
//   - 5-bit opcode constants (ir[31:27])
//   - ALU opcode encodings driven on alu_op
//   - control-step state enum (IDLE, T0..T7, HALT)
//   - opcode class enum and helpers used by the sequencer and step decoder
//   - bus-source bit indices 0..23 (one-hot bus_src order / mux select value)
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcodes (ir[31:27]). Any value not listed here executes as a nop.
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  // ALU operation encodings.
  typedef enum logic [4:0] {
    ALU_NONE = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_SHL  = 5'd5,
    ALU_SHR  = 5'd6,
    ALU_ROR  = 5'd7,
    ALU_ROL  = 5'd8,
    ALU_MUL  = 5'd9,
    ALU_DIV  = 5'd10
  } aluOpT;

  // Control steps. T0..T7 are consecutive so the sequencer can advance by +1.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } stateT;

  // Opcode classes: instructions in a class share the same step sequence.
  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_LD     = 3'd3,
    CLS_ST     = 3'd4,
    CLS_MULDIV = 3'd5,
    CLS_HALT   = 3'd6
  } opClassT;

  // Bus source indices (bit position in bus_src, also the encoded mux select).
  localparam int         BUS_W      = 24;
  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHIGH  = 5'd18;
  localparam logic [4:0] BUS_ZLOW   = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;
  localparam logic [4:0] BUS_CSIGN  = 5'd23;

  function automatic opClassT opClass(input logic [4:0] op);
    opClassT cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_ROR, OP_ROL:  cls = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:        cls = CLS_IMM;
      OP_LD:                           cls = CLS_LD;
      OP_ST:                           cls = CLS_ST;
      OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  // ALU operation used in T4. ld/st reuse ADD for the effective address.
  function automatic aluOpT aluFor(input logic [4:0] op);
    aluOpT alu;
    case (op)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: alu = ALU_ADD;
      OP_SUB:                        alu = ALU_SUB;
      OP_AND, OP_ANDI:               alu = ALU_AND;
      OP_OR, OP_ORI:                 alu = ALU_OR;
      OP_SHL:                        alu = ALU_SHL;
      OP_SHR:                        alu = ALU_SHR;
      OP_ROR:                        alu = ALU_ROR;
      OP_ROL:                        alu = ALU_ROL;
      OP_MUL:                        alu = ALU_MUL;
      OP_DIV:                        alu = ALU_DIV;
      default:                       alu = ALU_NONE;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// -----------------------------------------------------------------------------
// ctrl_step_decode
// Purely combinational step decoder: maps the current control step and the
// instruction fields to every datapath control output (Moore outputs of the
// sequencer). All outputs are 0 in IDLE and in any step an instruction does not
// use; in HALT only halted is set.
// Ports:
//   state          in   current control step
//   op, ra, rb, rc in   instruction fields
//   bus_src        out  one-hot bus source (at most one bit set)
//   rf_in          out  one-hot register-file load enable
//   pc_in .. lo_in out  register load enables
//   inc_pc         out  ALU computes PC+1 into Z
//   alu_op         out  ALU operation
//   mem_read/write out  memory strobes
//   halted         out  in HALT
// -----------------------------------------------------------------------------
module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  stateT       state,
  input  logic [4:0]  op,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic [23:0] bus_src,
  output logic [15:0] rf_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted
);

  opClassT    cls;
  // The bus source and register load are kept as (enable, index) pairs and
  // expanded to one-hot below, so more than one bit can never be set.
  logic       busEn;
  logic [4:0] busSel;
  logic       rfEn;
  logic [3:0] rfSel;

  assign cls = opClass(op);

  always_comb begin
    busEn     = 1'b0;
    busSel    = 5'd0;
    rfEn      = 1'b0;
    rfSel     = 4'd0;
    pc_in     = 1'b0;
    ir_in     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    inc_pc    = 1'b0;
    alu_op    = ALU_NONE;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;

    case (state)
      S_T0: begin
        busEn  = 1'b1;
        busSel = BUS_PC;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        busEn    = 1'b1;
        busSel   = BUS_ZLOW;
        pc_in    = 1'b1;
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        busEn  = 1'b1;
        busSel = BUS_MDR;
        ir_in  = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            busEn  = 1'b1;
            busSel = {1'b0, rb};
            y_in   = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            // R0 as base register means "no base": nothing drives the bus
            // and it reads 0, so the address is just the constant.
            busEn  = (rb != 4'd0);
            busSel = {1'b0, rb};
            y_in   = 1'b1;
          end
          CLS_MULDIV: begin
            busEn  = 1'b1;
            busSel = {1'b0, ra};
            y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_RTYPE: begin
            busEn  = 1'b1;
            busSel = {1'b0, rc};
            alu_op = aluFor(op);
            z_in   = 1'b1;
          end
          CLS_IMM, CLS_LD, CLS_ST: begin
            busEn  = 1'b1;
            busSel = BUS_CSIGN;
            alu_op = aluFor(op);
            z_in   = 1'b1;
          end
          CLS_MULDIV: begin
            busEn  = 1'b1;
            busSel = {1'b0, rb};
            alu_op = aluFor(op);
            z_in   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            busEn  = 1'b1;
            busSel = BUS_ZLOW;
            rfEn   = 1'b1;
            rfSel  = ra;
          end
          CLS_LD, CLS_ST: begin
            busEn  = 1'b1;
            busSel = BUS_ZLOW;
            mar_in = 1'b1;
          end
          CLS_MULDIV: begin
            busEn  = 1'b1;
            busSel = BUS_ZLOW;
            lo_in  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_LD: begin
            mem_read = 1'b1;
            mdr_in   = 1'b1;
          end
          CLS_ST: begin
            busEn  = 1'b1;
            busSel = {1'b0, ra};
            mdr_in = 1'b1;
          end
          CLS_MULDIV: begin
            busEn  = 1'b1;
            busSel = BUS_ZHIGH;
            hi_in  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CLS_LD: begin
            busEn  = 1'b1;
            busSel = BUS_MDR;
            rfEn   = 1'b1;
            rfSel  = ra;
          end
          CLS_ST: begin
            mem_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUS_W; gi++) begin : gBusSrc
      assign bus_src[gi] = busEn && (busSel == 5'(gi));
    end
    for (gi = 0; gi < 16; gi++) begin : gRfIn
      assign rf_in[gi] = rfEn && (rfSel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multi-cycle control unit for the CPU's shared 32-bit internal bus. Holds the
// control-step register (IDLE, T0..T7, HALT), the optional memory wait counter
// and the sticky mem_err flag; all datapath controls come from
// ctrl_step_decode as Moore outputs of (state, ir).
//
// Build option: SEQ_MEM_WAIT_EN
//   defined   - memory steps (fetch T1, ld T6, st T7) repeat until mem_ready;
//               after MEM_WAIT_MAX repeats mem_err is set and the unit halts.
//   undefined - every memory step takes one cycle, mem_ready is ignored and
//               mem_err is tied to 0.
//
// Ports:
//   clock      in   rising-edge clock
//   clear      in   synchronous active-low reset (forces IDLE, clears mem_err)
//   run        in   1 = fetch/execute; sampled only at instruction boundaries
//   ir         in   instruction: op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15]
//   mem_ready  in   memory completes this cycle
//   bus_src    out  one-hot bus source
//   rf_in      out  one-hot register-file load
//   pc_in .. lo_in, inc_pc, alu_op, mem_read, mem_write  out  datapath controls
//   halted     out  in HALT
//   mem_err    out  sticky memory wait timeout
//
// The T2 exit decision (nop / halt / continue) uses the op on ir during T2,
// so the datapath must present the instruction being loaded on ir by then.
// -----------------------------------------------------------------------------
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [23:0] bus_src,
  output logic [15:0] rf_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic [4:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        mem_err
);

  stateT      stateReg;
  stateT      stateNext;
  opClassT    cls;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       memStep;
  logic       lastStep;
  logic       stepDone;
  logic       waitTimeout;
  logic [14:0] unusedIrLow;

  assign op  = ir[31:27];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];
  assign cls = opClass(op);
  // Constant / address bits feed the datapath's C_sign_extended path directly.
  assign unusedIrLow = ir[14:0];

  assign memStep = (stateReg == S_T1) ||
                   (stateReg == S_T6 && cls == CLS_LD) ||
                   (stateReg == S_T7 && cls == CLS_ST);

  // T7 always ends an instruction, so a changing ir can never walk the step
  // counter past T7 into the HALT encoding.
  assign lastStep = (stateReg == S_T2 && cls == CLS_NOP) ||
                    (stateReg == S_T5 && (cls == CLS_RTYPE || cls == CLS_IMM)) ||
                    (stateReg == S_T6 && cls == CLS_MULDIV) ||
                    (stateReg == S_T7);

`ifdef SEQ_MEM_WAIT_EN
  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  logic [WAIT_W-1:0] waitCountReg;
  logic [WAIT_W-1:0] waitCountNext;
  logic              memErrReg;

  // waitCountReg = number of repeats already spent in the current memory step.
  assign stepDone    = !memStep || mem_ready;
  assign waitTimeout = memStep && !mem_ready &&
                       (waitCountReg == WAIT_W'(MEM_WAIT_MAX));

  always_comb begin
    waitCountNext = '0;
    if (memStep && !mem_ready) begin
      waitCountNext = waitCountReg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      waitCountReg <= '0;
      memErrReg    <= 1'b0;
    end else begin
      waitCountReg <= waitCountNext;
      if (waitTimeout) begin
        memErrReg <= 1'b1;
      end
    end
  end

  assign mem_err = memErrReg;
`else
  logic unusedWait;

  assign stepDone    = 1'b1;
  assign waitTimeout = 1'b0;
  assign mem_err     = 1'b0;
  assign unusedWait  = mem_ready | (MEM_WAIT_MAX == 0);
`endif

  always_ff @(posedge clock) begin
    if (!clear) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_IDLE: begin
        if (run) begin
          stateNext = S_T0;
        end
      end
      S_HALT: begin
        stateNext = S_HALT;
      end
      default: begin
        if (waitTimeout) begin
          stateNext = S_HALT;
        end else if (stepDone) begin
          if (stateReg == S_T2 && cls == CLS_HALT) begin
            stateNext = S_HALT;
          end else if (lastStep) begin
            stateNext = run ? S_T0 : S_IDLE;
          end else begin
            stateNext = stateT'(stateReg + 4'd1);
          end
        end
      end
    endcase
  end

  ctrl_step_decode uDecode (
    .state     (stateReg),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .bus_src   (bus_src),
    .rf_in     (rf_in),
    .pc_in     (pc_in),
    .ir_in     (ir_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .hi_in     (hi_in),
    .lo_in     (lo_in),
    .inc_pc    (inc_pc),
    .alu_op    (alu_op),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .halted    (halted)
  );

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit that sequences the CPU's shared 32-bit internal bus. Each control step it drives:
- a one-hot bus-source request, which the encoder reduces to the 5-bit mux select;
- register load enables, ALU opcode and memory strobes.

It covers fetch (T0–T2) and the execute steps of the supported opcodes. It sits between the instruction register and the bus/register datapath.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: cycles allowed in a memory wait step before `mem_err` (used only with SEQ_MEM_WAIT_EN)

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-low reset
- run  in  1  level; 1 = fetch/execute instructions
- ir  in  32  instruction register; op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15]
- mem_ready  in  1  memory completes read/write this cycle
- bus_src  out  24  one-hot bus source, bit order:
  - bits 0–15: R0–R15
  - 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended
- rf_in  out  16  one-hot register-file load
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in  out  1 each  register load enables
- inc_pc  out  1  ALU computes PC+1 into Z
- alu_op  out  5  ALU opcode (package encoding)
- mem_read, mem_write  out  1  memory strobes
- halted  out  1  HALT state reached
- mem_err  out  1  sticky wait-timeout flag

## Operation
- **Output model:** Moore outputs, decoded from the state register and `ir`. Every output is 0 outside the listed steps.
- **Bus source rule:** `bus_src` has at most one bit set in any cycle.
- **Register field, Rx:** rb = 0 in the base-address role (ld/st T3) drives no source; the bus reads 0.
- **States:** IDLE, T0–T7, HALT.
- **IDLE:** go to T0 when `run` = 1.
- **Fetch:**
  - T0: bus_src PC, mar_in, inc_pc, z_in.
  - T1: bus_src Zlow, pc_in, mem_read, mdr_in.
  - T2: bus_src MDR, ir_in.
- **R-type** (add, sub, and, or, shl, shr, ror, rol: ra ← rb op rc):
  - T3: R[rb], y_in.
  - T4: R[rc], alu_op, z_in.
  - T5: Zlow, rf_in[ra].
- **Immediate** (addi, andi, ori): same steps, except T4 drives C_sign_extended instead of R[rc].
- **ld:**
  - T3: R[rb], y_in.
  - T4: C, ADD, z_in.
  - T5: Zlow, mar_in.
  - T6: mem_read, mdr_in.
  - T7: MDR, rf_in[ra].
- **st:**
  - T3–T5: same as ld.
  - T6: R[ra], mdr_in.
  - T7: mem_write.
- **mul/div:**
  - T3: R[ra], y_in.
  - T4: R[rb], alu_op, z_in.
  - T5: Zlow, lo_in.
  - T6: Zhigh, hi_in.
- **nop:** ends after T2.
- **halt:** T2 → HALT. HALT is left only by `clear`. `halted` = 1 while in HALT.
- **Undefined opcode:** treated as nop.
- **End of instruction:** go to T0 if `run` = 1, else IDLE. `run` is sampled only at instruction boundaries; clearing it mid-instruction completes the instruction.
- **Reset:** `clear` low at any step (including mid-wait) forces IDLE on the next edge; `mem_err` = 0. All outputs are 0 while in IDLE.

## Timing
- One control step per clock. Enables take effect at the rising edge that ends the step.
- Fixed latencies (no waits):
  - fetch: 3 cycles
  - R-type/immediate: 6
  - ld/st: 8
  - mul/div: 7
  - nop: 3
- **Memory steps (T1 fetch, ld T6, st T7):** with waits enabled, the step repeats with identical outputs until `mem_ready` = 1. The step exits on the edge where `mem_ready` = 1; same-cycle ready means no added latency.
- **Wait timeout:** if MEM_WAIT_MAX repeats elapse, set `mem_err` and go to HALT.
- **ir stability:** `ir` must be stable from T3 through the end of the instruction. Only T2 loads IR.

## Configuration
- **SEQ_MEM_WAIT_EN defined:**
  - memory steps stall on `mem_ready`;
  - wait counter (4 bits for MEM_WAIT_MAX = 15) and `mem_err` logic are present.
- **SEQ_MEM_WAIT_EN undefined:**
  - every memory step is exactly one cycle; `mem_ready` is ignored;
  - `mem_err` is tied 0.

## Structure
- **Package cpu_ctrl_pkg:**
  - opcode constants (5-bit);
  - alu_op encodings;
  - state enum;
  - bus-source bit indices 0–23 (shared with the bus encoder).
- **Sub-module ctrl_step_decode:** combinational; maps (state, op, ra/rb/rc) to all output signals. The top holds the state register, wait counter and `mem_err`.

## Test plan
- **Reset:** `clear` = 0 for 2 cycles, `run` = 1 → all outputs 0, state IDLE. Release → T0 next cycle with bus_src = bit 20, mar_in = inc_pc = z_in = 1.
- **R-type add:** `ir` = add R3, R1, R2 →
  - T3: bus_src bit 1, y_in.
  - T4: bus_src bit 2, alu_op ADD, z_in.
  - T5: bus_src bit 19, rf_in = 0x0008.
  - Total 6 cycles.
- **ld with base R0:** `ir` = ld R5, 0x10(R0) →
  - T3: bus_src = 0.
  - T7: bus_src bit 21, rf_in = 0x0020.
  - No waits: 8 cycles total.
- **Memory wait (SEQ_MEM_WAIT_EN):**
  - `mem_ready` low 3 cycles in fetch T1 → T1 held 4 cycles with outputs constant.
  - `mem_ready` never asserted → `mem_err` = 1 and HALT after 15 repeats.
- **mul, halt, run:** `ir` = mul R4, R6 →
  - T5: lo_in, bus_src bit 19.
  - T6: hi_in, bus_src bit 18.
  - Then halt: `halted` = 1 and held until `clear`.
  - Dropping `run` mid-instruction → instruction completes, then IDLE.
- **Property:** for all cycles, `bus_src` and `rf_in` are each zero or one-hot.
